// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the four-requester memory arbiter.
// The MEM_ARB_FIXED_PRIORITY_EN build option is consumed by rr_pick4.
package mem_arb_pkg;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned REQ_IDX_W  = 2;
  localparam int unsigned DEF_WINDOW = 7;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;
  typedef logic [NUM_REQ-1:0]   gnt_t;

  // Default window base addresses, one window per requester.
  localparam int unsigned START_ADDR [NUM_REQ] = '{0, DEF_WINDOW, 2 * DEF_WINDOW, 3 * DEF_WINDOW};
endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way picker: round-robin starting after i_last, or fixed
// priority 0>1>2>3 when MEM_ARB_FIXED_PRIORITY_EN is defined.
module rr_pick4
  import mem_arb_pkg::*;
(
  input  gnt_t     i_req,
  input  req_idx_t i_last,
  output gnt_t     o_gnt,
  output req_idx_t o_idx,
  output logic     o_any
);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last;
`endif

  always_comb begin
    req_idx_t w_cand;
    w_cand = '0;
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      w_cand = REQ_IDX_W'(k);
`else
      w_cand = i_last + REQ_IDX_W'(k + 1);
`endif
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end
endmodule

// File: rtl/single_port_mem.sv
// Single-port synchronous RAM: one write or read per cycle, 1-cycle read latency.
// Contents are not reset.
module single_port_mem #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 28,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  q
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[addr] <= din;
    q <= r_mem[addr];
  end
endmodule

// File: rtl/mem_4_to_1_arbiter.sv
// Shares one single-port memory between four windowed requesters with
// req/gnt handshakes, read-valid tracking and sticky out-of-window detection.
// Build option MEM_ARB_FIXED_PRIORITY_EN selects fixed priority in rr_pick4.
module mem_4_to_1_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH                = 64,
  parameter int unsigned SINGLE_MEM_DEPTH     = 7,
  parameter int unsigned FULL_MEM_DEPTH       = 28,
  parameter int unsigned SINGLE_MEM_DEPTH_LOG = $clog2(SINGLE_MEM_DEPTH),
  parameter int unsigned FULL_MEM_DEPTH_LOG   = $clog2(FULL_MEM_DEPTH),
  parameter int unsigned MEM_0_START_ADDR     = START_ADDR[0],
  parameter int unsigned MEM_1_START_ADDR     = START_ADDR[1],
  parameter int unsigned MEM_2_START_ADDR     = START_ADDR[2],
  parameter int unsigned MEM_3_START_ADDR     = START_ADDR[3]
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_0,
  input  logic                            req_1,
  input  logic                            req_2,
  input  logic                            req_3,
  input  logic                            we_0,
  input  logic                            we_1,
  input  logic                            we_2,
  input  logic                            we_3,
  input  logic [SINGLE_MEM_DEPTH_LOG-1:0] addr_0,
  input  logic [SINGLE_MEM_DEPTH_LOG-1:0] addr_1,
  input  logic [SINGLE_MEM_DEPTH_LOG-1:0] addr_2,
  input  logic [SINGLE_MEM_DEPTH_LOG-1:0] addr_3,
  input  logic [WIDTH-1:0]                din_0,
  input  logic [WIDTH-1:0]                din_1,
  input  logic [WIDTH-1:0]                din_2,
  input  logic [WIDTH-1:0]                din_3,
  output logic                            gnt_0,
  output logic                            gnt_1,
  output logic                            gnt_2,
  output logic                            gnt_3,
  output logic                            rd_valid_0,
  output logic                            rd_valid_1,
  output logic                            rd_valid_2,
  output logic                            rd_valid_3,
  output logic [WIDTH-1:0]                mem_dout,
  output logic                            addr_err
);
  localparam logic [FULL_MEM_DEPTH_LOG-1:0] BASE [NUM_REQ] = '{
    FULL_MEM_DEPTH_LOG'(MEM_0_START_ADDR), FULL_MEM_DEPTH_LOG'(MEM_1_START_ADDR),
    FULL_MEM_DEPTH_LOG'(MEM_2_START_ADDR), FULL_MEM_DEPTH_LOG'(MEM_3_START_ADDR)};

  gnt_t                            w_req;
  gnt_t                            w_we;
  gnt_t                            w_gnt;
  req_idx_t                        w_idx;
  logic                            w_any;
  logic [SINGLE_MEM_DEPTH_LOG-1:0] w_addr [NUM_REQ];
  logic [WIDTH-1:0]                w_din  [NUM_REQ];
  logic [SINGLE_MEM_DEPTH_LOG-1:0] w_sel_addr;
  logic                            w_sel_we;
  logic                            w_in_win;
  logic [FULL_MEM_DEPTH_LOG-1:0]   w_phys;
  logic                            w_mem_wr;
  logic                            w_rd_fire;

  req_idx_t r_last_gnt;
  gnt_t     r_rd_valid;
  logic     r_addr_err;

  // Requests are masked during reset so no grant or memory access can occur.
  assign w_req  = {req_3, req_2, req_1, req_0} & {NUM_REQ{~rst}};
  assign w_we   = {we_3, we_2, we_1, we_0};
  assign w_addr = '{addr_0, addr_1, addr_2, addr_3};
  assign w_din  = '{din_0, din_1, din_2, din_3};

  rr_pick4 u_pick (
    .i_req  (w_req),
    .i_last (r_last_gnt),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_sel_addr = w_addr[w_idx];
  assign w_sel_we   = w_we[w_idx];
  assign w_in_win   = 32'(w_sel_addr) < SINGLE_MEM_DEPTH;
  assign w_phys     = FULL_MEM_DEPTH_LOG'(w_sel_addr) + BASE[w_idx];
  assign w_mem_wr   = w_any & w_sel_we & w_in_win;
  assign w_rd_fire  = w_any & ~w_sel_we & w_in_win;

  single_port_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (FULL_MEM_DEPTH),
    .ADDR_W (FULL_MEM_DEPTH_LOG)
  ) u_mem (
    .clk   (clk),
    .wr_en (w_mem_wr),
    .addr  (w_phys),
    .din   (w_din[w_idx]),
    .q     (mem_dout)
  );

  // Pointer reset to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= REQ_IDX_W'(NUM_REQ - 1);
      r_rd_valid <= '0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_any) r_last_gnt <= w_idx;
      r_rd_valid <= w_rd_fire ? w_gnt : '0;
      if (w_any && !w_in_win) r_addr_err <= 1'b1;
    end
  end

  assign gnt_0      = w_gnt[0];
  assign gnt_1      = w_gnt[1];
  assign gnt_2      = w_gnt[2];
  assign gnt_3      = w_gnt[3];
  assign rd_valid_0 = r_rd_valid[0];
  assign rd_valid_1 = r_rd_valid[1];
  assign rd_valid_2 = r_rd_valid[2];
  assign rd_valid_3 = r_rd_valid[3];
  assign addr_err   = r_addr_err;
endmodule

// File: tb/tb_mem_4_to_1_arbiter.sv
// Scoreboard bench for mem_4_to_1_arbiter: randomized requesters against a
// windowed-memory reference model; honours MEM_ARB_FIXED_PRIORITY_EN.
module tb_mem_4_to_1_arbiter;
  localparam int SD = 7;
  localparam int FD = 28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  we = '0;
  logic [2:0]  addr [4];
  logic [63:0] din [4];
  logic [3:0]  gnt;
  logic [3:0]  rdv;
  logic [63:0] mem_dout;
  logic        addr_err;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          due;
    int          idx;
    bit          chk;
    logic [63:0] data;
  } rd_exp_t;

  rd_exp_t     rq[$];
  int          tick = 0;
  int          last = 3;
  bit          err_exp = 1'b0;
  logic [3:0]  exp_gnt = '0;
  logic [63:0] mdl [FD];
  bit          mv [FD];

  mem_4_to_1_arbiter dut (
    .clk(clk), .rst(rst),
    .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]),
    .we_0(we[0]), .we_1(we[1]), .we_2(we[2]), .we_3(we[3]),
    .addr_0(addr[0]), .addr_1(addr[1]), .addr_2(addr[2]), .addr_3(addr[3]),
    .din_0(din[0]), .din_1(din[1]), .din_2(din[2]), .din_3(din[3]),
    .gnt_0(gnt[0]), .gnt_1(gnt[1]), .gnt_2(gnt[2]), .gnt_3(gnt[3]),
    .rd_valid_0(rdv[0]), .rd_valid_1(rdv[1]), .rd_valid_2(rdv[2]), .rd_valid_3(rdv[3]),
    .mem_dout(mem_dout), .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: picks the winner from the request vector, tracks memory words.
  always @(negedge clk) begin : model
    int e;
    int ph;
    if (rst) begin
      last = 3;
      err_exp = 1'b0;
      exp_gnt = '0;
      rq.delete();
    end else begin
      chk("addr_err", 64'(addr_err), 64'(err_exp));
      e = -1;
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        if (e < 0 && req[k]) e = k;
`else
        if (e < 0 && req[(last + 1 + k) % 4]) e = (last + 1 + k) % 4;
`endif
      end
      exp_gnt = (e >= 0) ? 4'(1 << e) : 4'b0;
      chk("gnt", 64'(gnt), 64'(exp_gnt));
      if (e >= 0) begin
        last = e;
        if (int'(addr[e]) < SD) begin
          ph = SD * e + int'(addr[e]);
          if (we[e]) begin
            mdl[ph] = din[e];
            mv[ph] = 1'b1;
          end else begin
            rq.push_back('{tick + 1, e, mv[ph], mdl[ph]});
          end
        end else begin
          err_exp = 1'b1;
        end
      end
    end
  end

  // Monitor: every read-valid pulse must match the oldest due expectation.
  always @(negedge clk) begin : monitor
    logic [3:0] er;
    if (!rst) begin
      er = '0;
      if (rq.size() > 0 && rq[0].due == tick) er = 4'(1 << rq[0].idx);
      chk("rd_valid", 64'(rdv), 64'(er));
      if (er != 4'b0) begin
        if (rq[0].chk) chk("mem_dout", mem_dout, rq[0].data);
        void'(rq.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic access(input int i, input bit w, input logic [2:0] a, input logic [63:0] d);
    bit ok;
    ok = 1'b0;
    req[i] = 1'b1;
    we[i] = w;
    addr[i] = a;
    din[i] = d;
    for (int c = 0; c < 16 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (exp_gnt[i]) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL grant_timeout req=%0d actual=none required=grant", i);
    end
    @(posedge clk);
    #1 req[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0;
      din[i] = '0;
    end
    // Request held during reset must not be granted.
    req = 4'b0001;
    we = 4'b0001;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rd_valid", 64'(rdv), 64'd0);
    chk("rst_addr_err", 64'(addr_err), 64'd0);
    req = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    access(0, 1'b1, 3'd2, 64'hA5);
    access(0, 1'b0, 3'd2, 64'h0);
    idle(2);

    // All four requesters reading continuously.
    for (int i = 0; i < 4; i++) addr[i] = 3'(i);
    we = '0;
    req = 4'b1111;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 req = '0;
    idle(2);

    access(1, 1'b1, 3'd0, 64'h11);
    access(3, 1'b1, 3'd0, 64'h33);
    access(1, 1'b0, 3'd0, 64'h0);
    access(3, 1'b0, 3'd0, 64'h0);
    access(2, 1'b0, 3'd0, 64'h0);
    idle(2);

    for (int i = 0; i < 4; i++)
      for (int a = 0; a < SD; a++) access(i, 1'b1, 3'(a), {$urandom, $urandom});

    // Two requesters contending for three cycles.
    we = '0;
    addr[0] = 3'd1;
    addr[2] = 3'd1;
    req = 4'b0101;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 req = '0;
    idle(2);

    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || exp_gnt[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          we[i] = 1'($urandom_range(0, 1));
          addr[i] = ($urandom_range(0, 31) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
          din[i] = {$urandom, $urandom};
        end
      end
      @(posedge clk);
      #1;
    end
    req = '0;
    idle(3);

    access(2, 1'b0, 3'd7, 64'h0);
    idle(3);
    chk("addr_err_sticky", 64'(addr_err), 64'd1);

    // Reset arrives while requester 1's read is in flight.
    access(1, 1'b0, 3'd3, 64'h0);
    chk("rdv1_before_rst", 64'(rdv[1]), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rdv1_dropped", 64'(rdv[1]), 64'd0);
    chk("addr_err_cleared", 64'(addr_err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    we = '0;
    req = 4'b0011;
    @(negedge clk);
    #1 chk("gnt0_first", 64'(gnt), 64'd1);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    #1 chk("gnt1_next", 64'(gnt), 64'd2);
    @(posedge clk);
    #1 req[1] = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
